dma_nios2_gen2_0_cpu_mul_combine: RTL

Downstream stage of the CPU multiplier cell. Takes the three registered 16x16 partial products (lo*lo, lo*hi, hi*lo) and sums them into the 32-bit low word of an unsigned 32x32 product. The sum runs through a 2-stage pipeline: an adder stage, then a 2-entry output FIFO with valid/ready handshake toward the register-file writeback. Writeback may stall; results retire in order.

---
 rtl/dma_nios2_gen2_0_cpu_mul_combine.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dma_nios2_gen2_0_cpu_mul_combine.sv
// Sums the three 16x16 partial products into the low 32-bit product word through an
// adder stage and a 2-entry in-order output FIFO. Define DMA_MUL_OVF_EN to build overflow detection.
module dma_nios2_gen2_0_cpu_mul_combine #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    input  logic        M_src_hi_nz,
    input  logic        mul_in_valid,
    output logic        mul_in_ready,
    input  logic        mul_flush,
    output logic [31:0] mul_result,
    output logic        mul_ovf,
    output logic        mul_out_valid,
    input  logic        mul_out_ready,
    output logic [1:0]  mul_occupancy
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    logic        s1_valid_reg;
    logic [31:0] p1_reg;
    logic [15:0] s_hi_reg;
    logic [31:0] res_mem [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  occ_reg;

    logic        pop;
    logic        s1_adv;
    logic        accept;
    logic [15:0] s_hi_sum;
    logic [31:0] sum2;

`ifdef DMA_MUL_OVF_EN
    logic        s_hi_c_reg;
    logic        hi_any_reg;
    logic        ovf_mem [2];
    logic        s_hi_c;
    logic        cout;
    logic        ovf_next;

    assign {s_hi_c, s_hi_sum} = {1'b0, M_mul_cell_p2[15:0]} + {1'b0, M_mul_cell_p3[15:0]};
    assign {cout, sum2}       = {1'b0, p1_reg} + {1'b0, s_hi_reg, 16'h0000};
    assign ovf_next           = hi_any_reg | s_hi_c_reg | cout;
    assign mul_ovf            = mul_out_valid & ovf_mem[rd_ptr_reg];
`else
    logic unused_bits;

    assign s_hi_sum    = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    assign sum2        = p1_reg + {s_hi_reg, 16'h0000};
    assign mul_ovf     = 1'b0;
    assign unused_bits = ^{M_src_hi_nz, M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};
`endif

    assign mul_out_valid = (occ_reg != 2'd0);
    assign mul_occupancy = occ_reg;
    assign mul_result    = res_mem[rd_ptr_reg];
    assign pop           = mul_out_valid && mul_out_ready;
    // Stage 1 may drain into a full FIFO only when the head leaves in the same cycle.
    assign s1_adv        = s1_valid_reg && ((occ_reg != FULL_COUNT) || pop);
    assign mul_in_ready  = !s1_valid_reg || s1_adv;
    assign accept        = mul_in_valid && mul_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            p1_reg       <= '0;
            s_hi_reg     <= '0;
`ifdef DMA_MUL_OVF_EN
            s_hi_c_reg   <= 1'b0;
            hi_any_reg   <= 1'b0;
`endif
        end else begin
            if (mul_flush)
                s1_valid_reg <= 1'b0;
            else if (accept)
                s1_valid_reg <= 1'b1;
            else if (s1_adv)
                s1_valid_reg <= 1'b0;

            if (accept) begin
                p1_reg   <= M_mul_cell_p1;
                s_hi_reg <= s_hi_sum;
`ifdef DMA_MUL_OVF_EN
                s_hi_c_reg <= s_hi_c;
                hi_any_reg <= (|M_mul_cell_p2[31:16]) | (|M_mul_cell_p3[31:16]) | M_src_hi_nz;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                res_mem[i] <= '0;
`ifdef DMA_MUL_OVF_EN
                ovf_mem[i] <= 1'b0;
`endif
            end
        end else if (mul_flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (s1_adv) begin
                res_mem[wr_ptr_reg] <= sum2;
`ifdef DMA_MUL_OVF_EN
                ovf_mem[wr_ptr_reg] <= ovf_next;
`endif
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({s1_adv, pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule
